// File: rtl/countdown_timer.sv
// Prescaled down-counter with start/stop/auto-reload control.
// Two-state FSM; out, BUSY and DONE are all registered.
module countdown_timer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             START,
    input  logic             STOP,
    input  logic             AUTO_RELOAD,
    output logic [WIDTH-1:0] out,
    output logic             BUSY,
    output logic             DONE
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PRESC_MAX = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO      = '0;

    typedef enum logic [0:0] {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] reload;
    logic [PW-1:0]    presc;
    logic             tick;

    assign tick = (state == RUN) && (presc == PRESC_MAX);

    // NOTE: every register here is state, so only non-blocking assignments appear below.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            out    <= '0;
            reload <= '0;
            presc  <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    presc <= '0;
                    // STOP has priority over START even when nothing is running.
                    if (START && !STOP) begin
                        out    <= LOAD_VAL;
                        reload <= LOAD_VAL;
                        if (LOAD_VAL != ZERO) begin
                            state <= RUN;
                            BUSY  <= 1'b1;
                        end else begin
                            DONE <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (STOP) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                        presc <= '0;
                    end else if (START) begin
                        out    <= LOAD_VAL;
                        reload <= LOAD_VAL;
                        presc  <= '0;
                        if (LOAD_VAL == ZERO) begin
                            DONE  <= 1'b1;
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end
                    end else if (tick) begin
                        presc <= '0;
                        // RUN is only entered with a non-zero count, so out >= 1 here.
                        if (out == ONE) begin
                            DONE <= 1'b1;
                            if (AUTO_RELOAD) begin
                                out <= reload;
                            end else begin
                                out   <= '0;
                                state <= IDLE;
                                BUSY  <= 1'b0;
                            end
                        end else begin
                            out <= out - ONE;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one DIV=1 instance and one DIV=4 instance
// share clock, reset and controls except START.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] load_val = '0;
    logic       start = 1'b0;
    logic       start4 = 1'b0;
    logic       stop = 1'b0;
    logic       auto_reload = 1'b0;
    logic [7:0] out1, out4;
    logic       busy1, busy4, done1, done4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(8), .DIV(1)) u1 (
        .CLK(clk), .RST(rst), .LOAD_VAL(load_val), .START(start), .STOP(stop),
        .AUTO_RELOAD(auto_reload), .out(out1), .BUSY(busy1), .DONE(done1)
    );

    countdown_timer #(.WIDTH(8), .DIV(4)) u4 (
        .CLK(clk), .RST(rst), .LOAD_VAL(load_val), .START(start4), .STOP(stop),
        .AUTO_RELOAD(auto_reload), .out(out4), .BUSY(busy4), .DONE(done4)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [7:0] o, input logic b, input logic d);
        check({tag, ".out"}, 32'(out1), 32'(o));
        check({tag, ".busy"}, 32'(busy1), 32'(b));
        check({tag, ".done"}, 32'(done1), 32'(d));
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #3;
        check_state("reset", 8'd0, 1'b0, 1'b0);
        check("reset.out4", 32'(out4), 32'd0);
        #8 rst = 1'b0;
        tick();

        // Basic run, DIV=1, N=5
        load_val = 8'd5; start = 1'b1;
        tick();
        check_state("basic.start", 8'd5, 1'b1, 1'b0);
        start = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            tick();
            check_state("basic.run", 8'(i), (i != 0), (i == 0));
        end
        tick();
        check_state("basic.after", 8'd0, 1'b0, 1'b0);

        // Prescaler, DIV=4, N=3: DONE visible 12 edges after the start edge
        load_val = 8'd3; start4 = 1'b1;
        tick();
        check("presc.start.out", 32'(out4), 32'd3);
        check("presc.start.busy", 32'(busy4), 32'd1);
        start4 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            check("presc.out", 32'(out4), (c < 12) ? 32'(3 - c / 4) : 32'd0);
            check("presc.done", 32'(done4), 32'(c == 12));
            check("presc.busy", 32'(busy4), 32'(c < 12));
        end
        tick();
        check("presc.done_once", 32'(done4), 32'd0);
        check("presc.u1_idle", 32'(busy1), 32'd0);

        // Auto-reload, DIV=1, N=3: 3,2,1,3,2,1,...
        load_val = 8'd3; auto_reload = 1'b1; start = 1'b1;
        tick();
        check_state("ar.start", 8'd3, 1'b1, 1'b0);
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            check_state("ar.run", 8'(3 - c % 3), 1'b1, (c % 3 == 0));
        end
        auto_reload = 1'b0; stop = 1'b1;
        tick();
        check_state("ar.stop", 8'd3, 1'b0, 1'b0);
        stop = 1'b0;

        // STOP at out=6 holds the count with no DONE
        load_val = 8'd10; start = 1'b1;
        tick();
        check_state("stop.start", 8'd10, 1'b1, 1'b0);
        start = 1'b0;
        repeat (4) tick();
        check_state("stop.pre", 8'd6, 1'b1, 1'b0);
        stop = 1'b1;
        tick();
        check_state("stop.hit", 8'd6, 1'b0, 1'b0);
        stop = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_state("stop.hold", 8'd6, 1'b0, 1'b0);
        end

        // START and STOP together in RUN: STOP wins
        load_val = 8'd10; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_state("prio.pre", 8'd9, 1'b1, 1'b0);
        load_val = 8'd20; start = 1'b1; stop = 1'b1;
        tick();
        check_state("prio.hit", 8'd9, 1'b0, 1'b0);
        start = 1'b0; stop = 1'b0;
        tick();
        check_state("prio.after", 8'd9, 1'b0, 1'b0);

        // Restart at out=7 with LOAD_VAL=20
        load_val = 8'd10; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check_state("restart.pre", 8'd7, 1'b1, 1'b0);
        load_val = 8'd20; start = 1'b1;
        tick();
        check_state("restart.hit", 8'd20, 1'b1, 1'b0);
        start = 1'b0;
        tick();
        check_state("restart.dec", 8'd19, 1'b1, 1'b0);

        // START with LOAD_VAL=0 in RUN: DONE, back to IDLE
        load_val = 8'd0; start = 1'b1;
        tick();
        check_state("zero_run", 8'd0, 1'b0, 1'b1);
        start = 1'b0;
        tick();
        check_state("zero_run.after", 8'd0, 1'b0, 1'b0);

        // START with LOAD_VAL=0 in IDLE: single DONE, BUSY stays 0
        start = 1'b1;
        tick();
        check_state("zero_idle", 8'd0, 1'b0, 1'b1);
        start = 1'b0;
        tick();
        check_state("zero_idle.after", 8'd0, 1'b0, 1'b0);

        // Async reset between edges at out=4
        load_val = 8'd8; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check_state("arst.pre", 8'd4, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_state("arst.async", 8'd0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_state("arst.after", 8'd0, 1'b0, 1'b0);
        end

        // First START after reset is accepted on the next edge
        load_val = 8'd2; start = 1'b1;
        tick();
        check_state("post_rst.start", 8'd2, 1'b1, 1'b0);
        start = 1'b0;
        tick();
        tick();
        check_state("post_rst.done", 8'd0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: width of count, load value and out.
REQ-002 The block SHALL have parameter DIV, default 1, legal range 1..256: clock cycles per count tick (prescaler).
REQ-003 The block SHALL have port CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-004 The block SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port LOAD_VAL  input  WIDTH  start value, sampled only on an accepted START.
REQ-006 The block SHALL have port START  input  1  level sampled each cycle; high = request (re)start.
REQ-007 The block SHALL have port STOP  input  1  level sampled each cycle; high = abort the countdown.
REQ-008 The block SHALL have port AUTO_RELOAD  input  1  sampled at terminal count; high = restart from the stored value.
REQ-009 The block SHALL have port out  output  WIDTH  registered current count.
REQ-010 The block SHALL have port BUSY  output  1  registered; high while in state RUN.
REQ-011 The block SHALL have port DONE  output  1  registered one-cycle pulse at terminal count.

Function
REQ-012 The block SHALL implement a two-state FSM with states IDLE and RUN.
REQ-013 The block SHALL hold an internal reload register of WIDTH bits and a prescaler counter ranging 0..DIV-1.
REQ-014 A tick SHALL occur in RUN when the prescaler equals DIV-1; the prescaler SHALL then wrap to 0, otherwise increment.
REQ-015 In IDLE, the prescaler SHALL hold at 0.
REQ-016 In IDLE, START=1 with LOAD_VAL!=0 SHALL set out=LOAD_VAL, the reload register=LOAD_VAL and prescaler=0, and move to RUN.
REQ-017 In IDLE, START=1 with LOAD_VAL==0 SHALL set out=0, pulse DONE next cycle and remain in IDLE.
REQ-018 In RUN, each tick with out>1 SHALL decrement out by 1.
REQ-019 In RUN, a tick with out==1 SHALL set out=0 and assert DONE for exactly one cycle.
REQ-020 On the terminal tick with AUTO_RELOAD=0, the FSM SHALL go to IDLE (out=0).
REQ-021 On the terminal tick with AUTO_RELOAD=1, out SHALL load the reload register and the FSM SHALL stay in RUN; out never shows 0 in that case, but DONE still pulses.
REQ-022 Latency: START accepted at edge k with LOAD_VAL=N>0, DIV=D and no STOP SHALL give DONE=1 in exactly the cycle after edge k+N*D.
REQ-023 In RUN, START=1 SHALL restart: out=LOAD_VAL, reload register=LOAD_VAL, prescaler=0, no DONE; LOAD_VAL==0 SHALL behave per REQ-017 and go to IDLE.
REQ-024 In RUN, STOP=1 SHALL move to IDLE with out holding its current value, no DONE pulse, and prescaler cleared.
REQ-025 STOP and START both high in the same cycle: STOP SHALL win and START SHALL be ignored.
REQ-026 STOP in IDLE SHALL have no effect.
REQ-027 out SHALL never wrap below 0; a decrement from 0 SHALL be impossible by construction.
REQ-028 BUSY SHALL equal (state==RUN) and SHALL be registered, changing on the same edge as the state.
REQ-029 DONE SHALL never be high in two consecutive cycles unless DIV=1, AUTO_RELOAD=1 and the reload value is 1.

Reset
REQ-030 RST=1 SHALL immediately, without waiting for a CLK edge, force state=IDLE, out=0, BUSY=0, DONE=0, prescaler=0 and reload register=0.
REQ-031 RST asserted mid-countdown SHALL abort the countdown with no DONE pulse.
REQ-032 After RST deasserts, the first accepted START SHALL be the next posedge with START=1.

Verification
REQ-033 Basic run: DIV=1, LOAD_VAL=5, one-cycle START -> out runs 5,4,3,2,1,0 on successive edges; DONE high only with out=0; BUSY low after.
REQ-034 Prescaler: DIV=4, LOAD_VAL=3 -> out changes every 4 cycles; DONE 12 cycles after the start edge.
REQ-035 Auto-reload: DIV=1, LOAD_VAL=3, AUTO_RELOAD=1 -> out runs 3,2,1,3,2,1...; DONE every 3 cycles; BUSY stays 1.
REQ-036 Stop/priority: LOAD_VAL=10, STOP at out=6 -> out holds 6, BUSY=0, no DONE; START+STOP together in RUN -> STOP behaviour.
REQ-037 Restart and zero load: START with LOAD_VAL=20 at out=7 -> out=20 next cycle; START with LOAD_VAL=0 in IDLE -> single DONE, BUSY stays 0.
REQ-038 Async reset: RST pulse between clock edges at out=4 -> out=0, BUSY=0 before the next edge; no DONE afterwards.
